// File: rtl/cfi_pkg.sv
// Shared types for the CFI back end: log record layout, exception record and fault constants.
package cfi_pkg;

    localparam int unsigned VLEN = 32;
    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] CFI_FAULT_CAUSE = XLEN'(18);

    typedef enum logic [1:0] {
        CFI_BRANCH = 2'd0,
        CFI_JUMP   = 2'd1,
        CFI_CALL   = 2'd2,
        CFI_RETURN = 2'd3
    } cfi_kind_e;

    typedef struct packed {
        cfi_kind_e        kind;
        logic [VLEN-1:0]  pc;
        logic [VLEN-1:0]  target;
        logic             is_compressed;
    } cfi_log_t;

    typedef struct packed {
        logic [XLEN-1:0]  cause;
        logic [XLEN-1:0]  tval;
        logic             valid;
    } exception_t;

    function automatic exception_t make_fault(input logic [XLEN-1:0] tval);
        exception_t e;
        e.cause = CFI_FAULT_CAUSE;
        e.tval  = tval;
        e.valid = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/cfi_shadow_stack.sv
// Circular LIFO of return addresses; when wrap is enabled a push to a full stack
// overwrites the oldest entry and occupancy stays saturated.
module cfi_shadow_stack #(
    parameter int unsigned SS_DEPTH = 16,
    parameter int unsigned VLEN     = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       wrap_en,
    input  logic [VLEN-1:0]            push_data,
    output logic [VLEN-1:0]            top_o,
    output logic [$clog2(SS_DEPTH):0]  usage_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(SS_DEPTH);

    logic [VLEN-1:0]  mem [SS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W:0]   usage;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (usage == (PTR_W+1)'(SS_DEPTH));
    assign empty_o = (usage == '0);
    assign do_push = push && (!full_o || wrap_en);
    assign do_pop  = pop && !empty_o && !push;
    // top_ptr names the next free slot, so the newest entry sits one below it
    assign top_o   = mem[top_ptr - PTR_W'(1)];
    assign usage_o = usage;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            top_ptr <= '0;
            usage   <= '0;
        end else if (do_push) begin
            top_ptr <= top_ptr + PTR_W'(1);
            if (!full_o) begin
                usage <= usage + (PTR_W+1)'(1);
            end
        end else if (do_pop) begin
            top_ptr <= top_ptr - PTR_W'(1);
            usage   <= usage - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[top_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/cfi_backend_shadow_stack.sv
// Consumer of the CFI log FIFO: pops one record every two cycles, pushes call return
// addresses, checks returns against the shadow stack and latches a sticky fault.
module cfi_backend_shadow_stack
    import cfi_pkg::*;
#(
    parameter int unsigned SS_DEPTH          = 16,
    parameter bit          FAULT_ON_OVERFLOW = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  cfi_log_t                   log_i,
    input  logic                       queue_empty_i,
    output logic                       queue_pop_o,
    output exception_t                 cfi_fault_o,
    output logic [$clog2(SS_DEPTH):0]  ss_usage_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FAULT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    cfi_log_t        log_q;
    exception_t      fault_q, fault_d;
    logic            ss_push, ss_pop, ss_full, ss_empty;
    logic [VLEN-1:0] ss_top;
    logic [VLEN-1:0] ret_addr;

    assign ret_addr    = log_q.pc + (log_q.is_compressed ? VLEN'(2) : VLEN'(4));
    assign cfi_fault_o = fault_q;

    cfi_shadow_stack #(
        .SS_DEPTH (SS_DEPTH),
        .VLEN     (VLEN)
    ) u_stack (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (ss_push),
        .pop       (ss_pop),
        .wrap_en   (!FAULT_ON_OVERFLOW),
        .push_data (ret_addr),
        .top_o     (ss_top),
        .usage_o   (ss_usage_o),
        .full_o    (ss_full),
        .empty_o   (ss_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            log_q   <= '0;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (queue_pop_o) begin
                log_q <= log_i;
            end
        end
    end

    // A faulting record leaves the stack untouched; only the fault register changes.
    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        queue_pop_o = 1'b0;
        ss_push     = 1'b0;
        ss_pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!queue_empty_i) begin
                    queue_pop_o = 1'b1;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
                unique case (log_q.kind)
                    CFI_CALL: begin
                        if (ss_full && FAULT_ON_OVERFLOW) begin
                            fault_d = make_fault(XLEN'(log_q.pc));
                            state_d = FAULT;
                        end else begin
                            ss_push = 1'b1;
                        end
                    end
                    CFI_RETURN: begin
                        if (!ss_empty) begin
                            if (log_q.target == ss_top) begin
                                ss_pop = 1'b1;
                            end else begin
                                fault_d = make_fault(XLEN'(log_q.target));
                                state_d = FAULT;
                            end
                        end else if (FAULT_ON_OVERFLOW) begin
                            fault_d = make_fault(XLEN'(log_q.target));
                            state_d = FAULT;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            FAULT: begin
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cfi_backend_shadow_stack.sv
// Bench for cfi_backend_shadow_stack: two instances (faulting and wrapping overflow policy)
// fed from bench-side FIFOs and checked every cycle against a queue-based model.
module tb_cfi_backend_shadow_stack;
    import cfi_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned UW    = $clog2(DEPTH) + 1;
    localparam bit FOO [2] = '{1'b1, 1'b0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    cfi_log_t      log_in  [2];
    logic          q_empty [2];
    logic          pop     [2];
    exception_t    fault   [2];
    logic [UW-1:0] usage   [2];

    cfi_log_t        fifo   [2][$];
    logic [VLEN-1:0] mstack [2][$];
    bit              m_busy [2];
    cfi_log_t        m_rec  [2];
    exception_t      m_fault [2];
    bit              pop_pending [2];
    int              pop_count [2];
    int              n_checks = 0;
    int              n_pass   = 0;
    bit              seen_reset = 1'b0;

    always #5 clk = ~clk;

    cfi_backend_shadow_stack #(.SS_DEPTH(DEPTH), .FAULT_ON_OVERFLOW(1'b1)) dut_fault (
        .clk_i(clk), .rst_i(rst), .log_i(log_in[0]), .queue_empty_i(q_empty[0]),
        .queue_pop_o(pop[0]), .cfi_fault_o(fault[0]), .ss_usage_o(usage[0])
    );

    cfi_backend_shadow_stack #(.SS_DEPTH(DEPTH), .FAULT_ON_OVERFLOW(1'b0)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .log_i(log_in[1]), .queue_empty_i(q_empty[1]),
        .queue_pop_o(pop[1]), .cfi_fault_o(fault[1]), .ss_usage_o(usage[1])
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic refreshFifo();
        for (int d = 0; d < 2; d++) begin
            q_empty[d] = (fifo[d].size() == 0);
            log_in[d]  = (fifo[d].size() == 0) ? '0 : fifo[d][0];
        end
    endtask

    function automatic void raiseFault(int d, logic [VLEN-1:0] v);
        m_fault[d].valid = 1'b1;
        m_fault[d].cause = XLEN'(18);
        m_fault[d].tval  = XLEN'(v);
    endfunction

    // Shadow stack modelled as a queue: back is newest, front is oldest.
    function automatic void modelApply(int d, cfi_log_t r);
        logic [VLEN-1:0] ra;
        if (r.kind == CFI_CALL) begin
            ra = r.pc + (r.is_compressed ? VLEN'(2) : VLEN'(4));
            if (mstack[d].size() < DEPTH) mstack[d].push_back(ra);
            else if (FOO[d]) raiseFault(d, r.pc);
            else begin
                mstack[d].delete(0);
                mstack[d].push_back(ra);
            end
        end else if (r.kind == CFI_RETURN) begin
            if (mstack[d].size() > 0) begin
                if (mstack[d][$] == r.target) mstack[d].delete(mstack[d].size() - 1);
                else raiseFault(d, r.target);
            end else if (FOO[d]) begin
                raiseFault(d, r.target);
            end
        end
    endfunction

    function automatic bit expPop(int d);
        return !m_busy[d] && !m_fault[d].valid && (fifo[d].size() > 0);
    endfunction

    function automatic bit allIdle();
        bit ok = 1'b1;
        for (int d = 0; d < 2; d++)
            if (m_busy[d] || (fifo[d].size() > 0 && !m_fault[d].valid)) ok = 1'b0;
        return ok;
    endfunction

    // Compare outputs against the model, then advance the model to the next rising edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst && seen_reset) begin
                checkOutput($sformatf("pop[%0d]", d), 64'(pop[d]), 64'(expPop(d)));
                checkOutput($sformatf("usage[%0d]", d), 64'(usage[d]), 64'(mstack[d].size()));
                checkOutput($sformatf("fault_valid[%0d]", d), 64'(fault[d].valid), 64'(m_fault[d].valid));
                checkOutput($sformatf("fault_cause[%0d]", d), 64'(fault[d].cause), 64'(m_fault[d].cause));
                checkOutput($sformatf("fault_tval[%0d]", d), 64'(fault[d].tval), 64'(m_fault[d].tval));
                if (pop[d]) pop_count[d]++;
            end
            if (rst) begin
                seen_reset     = 1'b1;
                m_busy[d]      = 1'b0;
                mstack[d].delete();
                m_fault[d]     = '0;
                pop_pending[d] = 1'b0;
            end else if (m_fault[d].valid) begin
            end else if (m_busy[d]) begin
                modelApply(d, m_rec[d]);
                m_busy[d] = 1'b0;
            end else if (fifo[d].size() > 0) begin
                m_rec[d]       = fifo[d][0];
                m_busy[d]      = 1'b1;
                pop_pending[d] = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (pop_pending[d] && fifo[d].size() > 0) fifo[d].delete(0);
            pop_pending[d] = 1'b0;
        end
        refreshFifo();
    end

    task automatic applyStimulus(input cfi_kind_e kind, input logic [VLEN-1:0] pc,
                                 input logic [VLEN-1:0] target, input logic compressed);
        cfi_log_t r;
        @(posedge clk);
        #2;
        r.kind = kind;
        r.pc = pc;
        r.target = target;
        r.is_compressed = compressed;
        for (int d = 0; d < 2; d++) fifo[d].push_back(r);
        refreshFifo();
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) fifo[d].delete();
        refreshFifo();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic waitIdle(input int max_cycles);
        int n = 0;
        while (!allIdle() && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (!allIdle()) begin
            n_checks++;
            $display("[TB] FAIL wait_idle: still busy after %0d cycles, required idle", max_cycles);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        int snap0, snap1;
        for (int d = 0; d < 2; d++) pop_count[d] = 0;
        refreshFifo();
        doReset();
        checkOutput("reset_usage", 64'(usage[0]), 64'd0);
        checkOutput("reset_fault", 64'(fault[0].valid), 64'd0);

        // Matching call/return, first one at a time, then back to back
        applyStimulus(CFI_CALL, 32'h8000_0100, 32'h0, 1'b0);
        waitIdle(50);
        checkOutput("t1_usage_call_f", 64'(usage[0]), 64'd1);
        checkOutput("t1_usage_call_w", 64'(usage[1]), 64'd1);
        applyStimulus(CFI_RETURN, 32'h0, 32'h8000_0104, 1'b0);
        waitIdle(50);
        checkOutput("t1_usage_ret", 64'(usage[0]), 64'd0);
        checkOutput("t1_no_fault", 64'(fault[0].valid), 64'd0);
        snap0 = pop_count[0];
        applyStimulus(CFI_CALL, 32'h8000_0100, 32'h0, 1'b0);
        applyStimulus(CFI_RETURN, 32'h0, 32'h8000_0104, 1'b0);
        waitIdle(50);
        checkOutput("t1_pops", 64'(pop_count[0] - snap0), 64'd2);

        // Compressed call returns to pc+2, so a pc+4 target is a violation
        doReset();
        applyStimulus(CFI_CALL, 32'h8000_0200, 32'h0, 1'b1);
        applyStimulus(CFI_RETURN, 32'h0, 32'h8000_0204, 1'b0);
        waitIdle(50);
        checkOutput("t2_fault_valid", 64'(fault[0].valid), 64'd1);
        checkOutput("t2_fault_cause", 64'(fault[0].cause), 64'd18);
        checkOutput("t2_fault_tval", 64'(fault[0].tval), 64'h8000_0204);
        checkOutput("t2_fault_wrap", 64'(fault[1].tval), 64'h8000_0204);
        snap0 = pop_count[0];
        applyStimulus(CFI_BRANCH, 32'h8000_0300, 32'h8000_0400, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        checkOutput("t2_no_pop", 64'(pop_count[0] - snap0), 64'd0);

        // Return on an empty stack
        doReset();
        snap0 = pop_count[0];
        snap1 = pop_count[1];
        applyStimulus(CFI_RETURN, 32'h0, 32'h0000_1234, 1'b0);
        applyStimulus(CFI_JUMP, 32'h0000_2000, 32'h0000_3000, 1'b0);
        waitIdle(50);
        checkOutput("t3_fault_f", 64'(fault[0].valid), 64'd1);
        checkOutput("t3_tval_f", 64'(fault[0].tval), 64'h1234);
        checkOutput("t3_fault_w", 64'(fault[1].valid), 64'd0);
        checkOutput("t3_pops_f", 64'(pop_count[0] - snap0), 64'd1);
        checkOutput("t3_pops_w", 64'(pop_count[1] - snap1), 64'd2);

        // Seventeen calls into a sixteen-entry stack
        doReset();
        snap1 = pop_count[1];
        for (int i = 0; i < 17; i++)
            applyStimulus(CFI_CALL, 32'h0000_1000 + 32'(i * 16), 32'h0, 1'b0);
        waitIdle(200);
        checkOutput("t4_fault_f", 64'(fault[0].valid), 64'd1);
        checkOutput("t4_tval_f", 64'(fault[0].tval), 64'h1100);
        checkOutput("t4_usage_f", 64'(usage[0]), 64'd16);
        checkOutput("t4_usage_w", 64'(usage[1]), 64'd16);
        checkOutput("t4_fault_w", 64'(fault[1].valid), 64'd0);
        for (int i = 16; i >= 0; i--)
            applyStimulus(CFI_RETURN, 32'h0, 32'h0000_1004 + 32'(i * 16), 1'b0);
        waitIdle(200);
        checkOutput("t4_usage_w_end", 64'(usage[1]), 64'd0);
        checkOutput("t4_fault_w_end", 64'(fault[1].valid), 64'd0);
        checkOutput("t4_pops_w", 64'(pop_count[1] - snap1), 64'd34);

        // Branch/jump burst with the FIFO running dry part way through
        doReset();
        snap0 = pop_count[0];
        for (int i = 0; i < 4; i++)
            applyStimulus((i % 2) ? CFI_JUMP : CFI_BRANCH, 32'h4000 + 32'(i * 4), 32'h5000, 1'b0);
        waitIdle(50);
        for (int i = 4; i < 10; i++)
            applyStimulus((i % 2) ? CFI_JUMP : CFI_BRANCH, 32'h4000 + 32'(i * 4), 32'h5000, 1'b0);
        waitIdle(50);
        checkOutput("t5_pops", 64'(pop_count[0] - snap0), 64'd10);
        checkOutput("t5_usage", 64'(usage[0]), 64'd0);
        checkOutput("t5_fault", 64'(fault[0].valid), 64'd0);

        // Reset while a call is in its check cycle
        doReset();
        for (int i = 0; i < 5; i++)
            applyStimulus(CFI_CALL, 32'h0000_6000 + 32'(i * 16), 32'h0, 1'b0);
        waitIdle(50);
        checkOutput("t6_usage5", 64'(usage[0]), 64'd5);
        applyStimulus(CFI_CALL, 32'h0000_7000, 32'h0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) fifo[d].delete();
        refreshFifo();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("t6_usage_f", 64'(usage[0]), 64'd0);
        checkOutput("t6_usage_w", 64'(usage[1]), 64'd0);
        checkOutput("t6_pop", 64'(pop[0]), 64'd0);
        checkOutput("t6_fault", 64'(fault[0]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
